route_demux2: RTL and testbench
===============================

ROUTE_DEMUX2 -- requirements
Module: route_demux2

Interface
REQ-001 The module SHALL have parameter DATA_W, default 32, giving the payload width of all data ports.
REQ-002 clk  input  1  sole clock; all state changes on its rising edge.
REQ-003 rst_n  input  1  asynchronous, active-low reset.
REQ-004 in_data  input  DATA_W  payload offered by the upstream producer.
REQ-005 in_sel  input  1  destination select: 0 steers to channel 1, 1 steers to channel 2.
REQ-006 in_valid  input  1  upstream asserts when in_data/in_sel are valid.
REQ-007 in_ready  output  1  block accepts the offered word this cycle.
REQ-008 out1_data / out2_data  output  DATA_W  head word of channel 1 / channel 2.
REQ-009 out1_valid / out2_valid  output  1  channel holds a word.
REQ-010 out1_ready / out2_ready  input  1  downstream consumer of the channel accepts the head word.
REQ-011 busy  output  1  high while either channel holds any word.

Function
REQ-012 The block SHALL accept a word on any cycle where in_valid=1 and in_ready=1, and SHALL write it to channel 1 when in_sel=0 or to channel 2 when in_sel=1.
REQ-013 A word pops from channel k on any cycle where outk_valid=1 and outk_ready=1.
REQ-014 An accepted word SHALL appear on its selected output on the cycle after acceptance, giving 1-cycle latency, with outk_valid=1 on that cycle.
REQ-015 Each channel SHALL be a FIFO: words leave in acceptance order, and the two channels are independent of each other.
REQ-016 in_ready SHALL depend only on the channel named by the current in_sel; a full, stalled channel SHALL NOT block traffic routed to the other channel.
REQ-017 outk_data and outk_valid SHALL stay stable while outk_valid=1 and outk_ready=0.
REQ-018 A push and a pop on the same channel in the same cycle SHALL both take effect, with occupancy unchanged, no word lost, and no word duplicated.
REQ-019 A push to one channel and a pop from the other in the same cycle SHALL both take effect.
REQ-020 If in_valid=0, no push SHALL occur, regardless of in_sel.
REQ-021 outk_data SHALL be don't-care while outk_valid=0; the bench SHALL NOT check it then.
REQ-022 busy SHALL equal out1_valid OR out2_valid.
REQ-023 outk_valid SHALL never rise without a prior push to channel k.
REQ-024 No data word SHALL pass from input to output combinationally.

Reset
REQ-025 While rst_n=0, out1_valid, out2_valid and busy SHALL be 0, and stored data SHALL be cleared to 0.
REQ-026 When rst_n is low, in_ready SHALL be 0.
REQ-027 Assertion of rst_n mid-transfer SHALL immediately discard all buffered words; no word SHALL be presented after reset deasserts.
REQ-028 in_ready SHALL become 1 no earlier than the first rising clk edge after rst_n deasserts.

Configuration
REQ-029 Macro ROUTE_DEMUX2_SKID_EN SHALL select the channel depth.
REQ-030 Without ROUTE_DEMUX2_SKID_EN, each channel SHALL be a 1-entry register, and in_ready SHALL equal (selected channel empty) OR (selected channel's outk_ready=1), a combinational path from outk_ready.
REQ-031 With ROUTE_DEMUX2_SKID_EN, each channel SHALL be a 2-entry FIFO with a wrap-around read/write pointer.
REQ-032 With ROUTE_DEMUX2_SKID_EN, in_ready SHALL equal (selected channel occupancy < 2), with no combinational path from outk_ready.
REQ-033 With ROUTE_DEMUX2_SKID_EN, full-rate streaming into one channel SHALL continue at one word per cycle while its consumer is ready.
REQ-034 With ROUTE_DEMUX2_SKID_EN, a channel SHALL absorb two words after its consumer stalls.

Verification
REQ-035 Reset: hold rst_n=0 for 3 cycles with in_valid=1 -> in_ready=0, out1_valid=0, out2_valid=0, busy=0; after release, push 0x0000_0001 to channel 1 -> out1_valid=1 next cycle with out1_data=0x0000_0001.
REQ-036 Routing: push 0xAAAA_0000 with sel=0, then 0xBBBB_0000 with sel=1, both consumers ready -> each word appears exactly once, on out1 and out2 respectively, one cycle after acceptance.
REQ-037 Isolation: hold out1_ready=0 and fill channel 1, then offer 0x1234_5678 with sel=1 -> in_ready=1, and the word exits out2 while out1_data holds its word stable.
REQ-038 Simultaneous push/pop: channel 1 full, out1_ready=1, push 0xCAFE_F00D with sel=0 -> old head pops and the new word is presented the next cycle, with no gap and no loss.
REQ-039 Depth: with ROUTE_DEMUX2_SKID_EN and out2_ready=0, push 3 words with sel=1 -> exactly 2 are accepted and in_ready=0 on the third; releasing out2_ready drains them in order. Without the macro the same stimulus accepts exactly 1 word.
REQ-040 Mid-operation reset: pulse rst_n low asynchronously while both channels hold words -> valids drop immediately without waiting for clk, and no stale word appears after release.

Source files
------------

// File: rtl/route_demux2.sv
// route_demux2: steers one input stream into two independent output channels.
// Define ROUTE_DEMUX2_SKID_EN for 2-entry channel FIFOs; default is 1-entry registers.
module route_demux2 #(
    parameter int unsigned DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [DATA_W-1:0] in_data,
    input  logic              in_sel,
    input  logic              in_valid,
    output logic              in_ready,
    output logic [DATA_W-1:0] out1_data,
    output logic              out1_valid,
    input  logic              out1_ready,
    output logic [DATA_W-1:0] out2_data,
    output logic              out2_valid,
    input  logic              out2_ready,
    output logic              busy
);

    // Holds in_ready low until the first clock edge after reset release.
    logic rdy_en_q;
    logic rdy_en_d;

    logic [1:0]             out_rdy;
    logic [1:0]             push;
    logic [1:0]             pop;
    logic [1:0]             ch_valid;
    logic [1:0][DATA_W-1:0] head;

    assign out_rdy = {out2_ready, out1_ready};
    assign rdy_en_d = 1'b1;

    assign push[0] = in_valid & in_ready & ~in_sel;
    assign push[1] = in_valid & in_ready & in_sel;
    assign pop     = ch_valid & out_rdy;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rdy_en_q <= 1'b0;
        end else begin
            rdy_en_q <= rdy_en_d;
        end
    end

`ifdef ROUTE_DEMUX2_SKID_EN

    logic [1:0][1:0][DATA_W-1:0] mem_q;
    logic [1:0][1:0][DATA_W-1:0] mem_d;
    logic [1:0]                  wr_ptr_q;
    logic [1:0]                  wr_ptr_d;
    logic [1:0]                  rd_ptr_q;
    logic [1:0]                  rd_ptr_d;
    logic [1:0][1:0]             cnt_q;
    logic [1:0][1:0]             cnt_d;

    // Registered occupancy only: no path from outk_ready to in_ready.
    assign in_ready = rdy_en_q & (cnt_q[in_sel] != 2'd2);

    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        cnt_d    = cnt_q;
        for (int unsigned k = 0; k < 2; k++) begin
            if (push[k]) begin
                mem_d[k][wr_ptr_q[k]] = in_data;
                wr_ptr_d[k]           = ~wr_ptr_q[k];
            end
            if (pop[k]) begin
                rd_ptr_d[k] = ~rd_ptr_q[k];
            end
            cnt_d[k] = cnt_q[k] + {1'b0, push[k]} - {1'b0, pop[k]};
        end
    end

    always_comb begin
        ch_valid = '0;
        head     = '0;
        for (int unsigned k = 0; k < 2; k++) begin
            ch_valid[k] = (cnt_q[k] != 2'd0);
            head[k]     = mem_q[k][rd_ptr_q[k]];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem_q    <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            cnt_q    <= cnt_d;
        end
    end

`else

    logic [1:0]             vld_q;
    logic [1:0]             vld_d;
    logic [1:0][DATA_W-1:0] dat_q;
    logic [1:0][DATA_W-1:0] dat_d;

    // A full channel still accepts when its consumer drains it this cycle.
    assign in_ready = rdy_en_q & (~vld_q[in_sel] | out_rdy[in_sel]);

    always_comb begin
        vld_d = vld_q;
        dat_d = dat_q;
        for (int unsigned k = 0; k < 2; k++) begin
            vld_d[k] = push[k] | (vld_q[k] & ~pop[k]);
            if (push[k]) begin
                dat_d[k] = in_data;
            end
        end
    end

    assign ch_valid = vld_q;
    assign head     = dat_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_q <= '0;
            dat_q <= '0;
        end else begin
            vld_q <= vld_d;
            dat_q <= dat_d;
        end
    end

`endif

    assign out1_valid = ch_valid[0];
    assign out2_valid = ch_valid[1];
    assign out1_data  = head[0];
    assign out2_data  = head[1];
    assign busy       = |ch_valid;

endmodule

// File: tb/tb_route_demux2.sv
// Testbench for route_demux2: directed table, hand sequences and randomized traffic
// checked against a queue-based reference model.
module tb_route_demux2;

`ifdef ROUTE_DEMUX2_SKID_EN
    localparam int DEPTH = 2;
`else
    localparam int DEPTH = 1;
`endif

    logic        clk;
    logic        rst_n;
    logic [31:0] in_data;
    logic        in_sel;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] out1_data;
    logic        out1_valid;
    logic        out1_ready;
    logic [31:0] out2_data;
    logic        out2_valid;
    logic        out2_ready;
    logic        busy;

    route_demux2 #(.DATA_W(32)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_data    (in_data),
        .in_sel     (in_sel),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .out1_data  (out1_data),
        .out1_valid (out1_valid),
        .out1_ready (out1_ready),
        .out2_data  (out2_data),
        .out2_valid (out2_valid),
        .out2_ready (out2_ready),
        .busy       (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    // Reference model: one queue per channel plus the post-reset ready enable.
    logic [31:0] q1[$];
    logic [31:0] q2[$];
    bit          m_rdy_en = 1'b0;

    typedef struct {
        logic        iv;
        logic        sel;
        logic [31:0] data;
        logic        r1;
        logic        r2;
        logic        e_rdy;
        logic        e_v1;
        logic [31:0] e_d1;
        logic        e_v2;
        logic [31:0] e_d2;
    } vec_t;

    vec_t tbl[9];

    function automatic vec_t mk(logic iv, logic sel, logic [31:0] data, logic r1, logic r2,
                                logic e_rdy, logic e_v1, logic [31:0] e_d1,
                                logic e_v2, logic [31:0] e_d2);
        vec_t v;
        v.iv = iv; v.sel = sel; v.data = data; v.r1 = r1; v.r2 = r2;
        v.e_rdy = e_rdy; v.e_v1 = e_v1; v.e_d1 = e_d1; v.e_v2 = e_v2; v.e_d2 = e_d2;
        return v;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    endtask

    function automatic bit m_ready(input logic sel, input logic r1, input logic r2);
        int  occ;
        bit  rdy;
        occ = sel ? q2.size() : q1.size();
        rdy = (occ < DEPTH) || (DEPTH == 1 && (sel ? r2 : r1));
        return m_rdy_en && rdy;
    endfunction

    task automatic check_model();
        chk("in_ready", {31'b0, in_ready}, {31'b0, m_ready(in_sel, out1_ready, out2_ready)});
        chk("out1_valid", {31'b0, out1_valid}, {31'b0, q1.size() != 0});
        chk("out2_valid", {31'b0, out2_valid}, {31'b0, q2.size() != 0});
        chk("busy", {31'b0, busy}, {31'b0, (q1.size() != 0) || (q2.size() != 0)});
        if (q1.size() != 0) chk("out1_data", out1_data, q1[0]);
        if (q2.size() != 0) chk("out2_data", out2_data, q2[0]);
    endtask

    task automatic drive(input logic iv, input logic sel, input logic [31:0] data,
                         input logic r1, input logic r2);
        in_valid   = iv;
        in_sel     = sel;
        in_data    = data;
        out1_ready = r1;
        out2_ready = r2;
        #1;
        check_model();
    endtask

    task automatic advance();
        bit do_push;
        bit pop1;
        bit pop2;
        do_push = in_valid && m_ready(in_sel, out1_ready, out2_ready);
        pop1    = (q1.size() != 0) && out1_ready;
        pop2    = (q2.size() != 0) && out2_ready;
        @(posedge clk);
        if (pop1) void'(q1.pop_front());
        if (pop2) void'(q2.pop_front());
        if (do_push) begin
            if (in_sel) q2.push_back(in_data);
            else        q1.push_back(in_data);
        end
        m_rdy_en = 1'b1;
        @(negedge clk);
    endtask

    initial begin
        logic [31:0] held;
        rst_n      = 1'b0;
        in_valid   = 1'b1;
        in_sel     = 1'b0;
        in_data    = 32'h5555_5555;
        out1_ready = 1'b1;
        out2_ready = 1'b1;

        // Reset held for three cycles with in_valid asserted
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("rst_in_ready", {31'b0, in_ready}, 32'd0);
            chk("rst_out1_valid", {31'b0, out1_valid}, 32'd0);
            chk("rst_out2_valid", {31'b0, out2_valid}, 32'd0);
            chk("rst_busy", {31'b0, busy}, 32'd0);
            chk("rst_out1_data", out1_data, 32'd0);
            chk("rst_out2_data", out2_data, 32'd0);
        end
        rst_n = 1'b1;
        #1;
        chk("rel_in_ready_before_edge", {31'b0, in_ready}, 32'd0);
        drive(1'b0, 1'b0, 32'h0, 1'b1, 1'b1);
        advance();
        drive(1'b1, 1'b0, 32'h0000_0001, 1'b1, 1'b1);
        chk("rst_first_push_ready", {31'b0, in_ready}, 32'd1);
        advance();
        drive(1'b0, 1'b0, 32'h0, 1'b1, 1'b1);
        chk("rst_first_v1", {31'b0, out1_valid}, 32'd1);
        chk("rst_first_d1", out1_data, 32'h0000_0001);
        advance();

        // Directed table: routing, no-push on in_valid=0, stall stability
        tbl[0] = mk(1, 0, 32'hAAAA_0000, 1, 1, 1, 0, 32'h0, 0, 32'h0);
        tbl[1] = mk(1, 1, 32'hBBBB_0000, 1, 1, 1, 1, 32'hAAAA_0000, 0, 32'h0);
        tbl[2] = mk(0, 1, 32'hDEAD_BEEF, 1, 1, 1, 0, 32'h0, 1, 32'hBBBB_0000);
        tbl[3] = mk(0, 0, 32'h0, 1, 1, 1, 0, 32'h0, 0, 32'h0);
        tbl[4] = mk(1, 1, 32'h0000_0055, 1, 0, 1, 0, 32'h0, 0, 32'h0);
        tbl[5] = mk(0, 1, 32'h0, 1, 0, (DEPTH == 2), 0, 32'h0, 1, 32'h0000_0055);
        tbl[6] = mk(0, 0, 32'h0, 1, 0, 1, 0, 32'h0, 1, 32'h0000_0055);
        tbl[7] = mk(0, 0, 32'h0, 1, 1, 1, 0, 32'h0, 1, 32'h0000_0055);
        tbl[8] = mk(0, 0, 32'h0, 1, 1, 1, 0, 32'h0, 0, 32'h0);
        for (int i = 0; i < 9; i++) begin
            drive(tbl[i].iv, tbl[i].sel, tbl[i].data, tbl[i].r1, tbl[i].r2);
            chk($sformatf("tbl%0d_rdy", i), {31'b0, in_ready}, {31'b0, tbl[i].e_rdy});
            chk($sformatf("tbl%0d_v1", i), {31'b0, out1_valid}, {31'b0, tbl[i].e_v1});
            chk($sformatf("tbl%0d_v2", i), {31'b0, out2_valid}, {31'b0, tbl[i].e_v2});
            if (tbl[i].e_v1) chk($sformatf("tbl%0d_d1", i), out1_data, tbl[i].e_d1);
            if (tbl[i].e_v2) chk($sformatf("tbl%0d_d2", i), out2_data, tbl[i].e_d2);
            advance();
        end

        // Isolation: channel 1 full and stalled, channel 2 still flows
        for (int i = 0; i < DEPTH; i++) begin
            drive(1'b1, 1'b0, 32'h0000_1000 + i, 1'b0, 1'b1);
            advance();
        end
        held = out1_data;
        drive(1'b1, 1'b0, 32'h0, 1'b0, 1'b1);
        chk("iso_ch1_full_not_ready", {31'b0, in_ready}, 32'd0);
        drive(1'b1, 1'b1, 32'h1234_5678, 1'b0, 1'b1);
        chk("iso_in_ready", {31'b0, in_ready}, 32'd1);
        advance();
        drive(1'b0, 1'b0, 32'h0, 1'b0, 1'b1);
        chk("iso_v2", {31'b0, out2_valid}, 32'd1);
        chk("iso_d2", out2_data, 32'h1234_5678);
        chk("iso_d1_stable", out1_data, held);
        chk("iso_d1_head", out1_data, 32'h0000_1000);
        advance();

        // Simultaneous push/pop on channel 1 at occupancy 1
        for (int i = 1; i < DEPTH; i++) begin
            drive(1'b0, 1'b0, 32'h0, 1'b1, 1'b1);
            advance();
        end
        drive(1'b1, 1'b0, 32'hCAFE_F00D, 1'b1, 1'b1);
        chk("pp_in_ready", {31'b0, in_ready}, 32'd1);
        chk("pp_old_head_valid", {31'b0, out1_valid}, 32'd1);
        advance();
        drive(1'b0, 1'b0, 32'h0, 1'b1, 1'b1);
        chk("pp_new_valid", {31'b0, out1_valid}, 32'd1);
        chk("pp_new_data", out1_data, 32'hCAFE_F00D);
        advance();
        drive(1'b0, 1'b0, 32'h0, 1'b1, 1'b1);
        chk("pp_drained", {31'b0, out1_valid}, 32'd0);

        // Depth: three offers into a stalled channel 2
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, 1'b1, 32'h0000_2000 + i, 1'b1, 1'b0);
            chk($sformatf("depth_rdy%0d", i), {31'b0, in_ready}, {31'b0, i < DEPTH});
            advance();
        end
        for (int i = 0; i < DEPTH; i++) begin
            drive(1'b0, 1'b0, 32'h0, 1'b1, 1'b1);
            chk($sformatf("depth_drain_v%0d", i), {31'b0, out2_valid}, 32'd1);
            chk($sformatf("depth_drain_d%0d", i), out2_data, 32'h0000_2000 + i);
            advance();
        end
        drive(1'b0, 1'b0, 32'h0, 1'b1, 1'b1);
        chk("depth_empty", {31'b0, out2_valid}, 32'd0);

        // Mid-operation asynchronous reset with both channels occupied
        drive(1'b1, 1'b0, 32'h0000_3001, 1'b0, 1'b0);
        advance();
        drive(1'b1, 1'b1, 32'h0000_3002, 1'b0, 1'b0);
        advance();
        drive(1'b0, 1'b0, 32'h0, 1'b0, 1'b0);
        chk("mid_pre_busy", {31'b0, busy}, 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("mid_v1_async", {31'b0, out1_valid}, 32'd0);
        chk("mid_v2_async", {31'b0, out2_valid}, 32'd0);
        chk("mid_busy_async", {31'b0, busy}, 32'd0);
        chk("mid_rdy_async", {31'b0, in_ready}, 32'd0);
        q1.delete();
        q2.delete();
        m_rdy_en = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            drive(1'b0, 1'b0, 32'h0, 1'b1, 1'b1);
            chk($sformatf("mid_post_v1_%0d", i), {31'b0, out1_valid}, 32'd0);
            chk($sformatf("mid_post_v2_%0d", i), {31'b0, out2_valid}, 32'd0);
            advance();
        end

        // Randomized traffic against the queue model
        for (int i = 0; i < 500; i++) begin
            drive(1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 1)), $urandom,
                  1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 2) != 0));
            advance();
        end
        for (int i = 0; i < 4; i++) begin
            drive(1'b0, 1'b0, 32'h0, 1'b1, 1'b1);
            advance();
        end
        drive(1'b0, 1'b0, 32'h0, 1'b1, 1'b1);
        chk("final_idle", {31'b0, busy}, 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
